// File: rtl/fetch_unit_if.sv
// Fetch-stage bundle type and the fetch <-> imem / issue-queue interface.
// Master side is the fetch unit; slave side is memory plus issue queue.
package fetch_pkg;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instruction;
        logic        branch;
        logic        jump;
        logic        prediction;
    } pipe_in_t;
endpackage

interface fetch_unit_if;
    import fetch_pkg::*;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    pipe_in_t    pipe_out;
    logic        pipe_valid;
    logic        iq_full;

    modport master (
        output imem_addr, pipe_out, pipe_valid,
        input  imem_rdata, iq_full
    );
    modport slave (
        input  imem_addr, pipe_out, pipe_valid,
        output imem_rdata, iq_full
    );
endinterface

// File: rtl/fetch_unit.sv
// Fetch stage: fetch register, branch/jump pre-decode, taken prediction.
// FETCH_BHT_EN selects a bimodal BHT; otherwise static backward-taken.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          BHT_ENTRIES = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [31:0]  pc_update,
    input  logic         mispredicted,
    input  logic         committed_is_branch,
    input  logic [31:0]  commit_pc,
    input  logic         commit_result,
    fetch_unit_if.master bus
);
    localparam int IDX = $clog2(BHT_ENTRIES);

    typedef enum logic {BOOT, RUN} state_e;

    state_e   state_q;
    pipe_in_t pipe_q, pipe_d;
    logic     valid_q;
    logic     adv;
    logic     br_dec;
    logic     jmp_dec;
    logic     pred;

    // Reset is sampled synchronously, so force RESET_PC while it is held.
    assign bus.imem_addr = (reset || state_q == BOOT) ? RESET_PC : pc_update;

    assign adv     = (state_q == BOOT) | ~bus.iq_full | mispredicted;
    assign br_dec  = (bus.imem_rdata[6:0] == 7'b1100011);
    assign jmp_dec = (bus.imem_rdata[6:0] == 7'b1101111);

`ifdef FETCH_BHT_EN
    logic [1:0]     bht_q [BHT_ENTRIES];
    logic [IDX-1:0] fetch_idx;
    logic [IDX-1:0] commit_idx;
    logic           unused_ok;

    assign fetch_idx  = bus.imem_addr[IDX+1:2];
    assign commit_idx = commit_pc[IDX+1:2];
    assign pred       = br_dec & bht_q[fetch_idx][1];
    assign unused_ok  = ^{commit_pc[1:0], commit_pc[31:IDX+2]};

    // Reads above see the pre-training value on a same-index collision.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < BHT_ENTRIES; i++)
                bht_q[i] <= 2'b01;
        end else if (committed_is_branch) begin
            if (commit_result && bht_q[commit_idx] != 2'b11)
                bht_q[commit_idx] <= bht_q[commit_idx] + 2'd1;
            else if (!commit_result && bht_q[commit_idx] != 2'b00)
                bht_q[commit_idx] <= bht_q[commit_idx] - 2'd1;
        end
    end
`else
    logic unused_ok;

    assign pred      = br_dec & bus.imem_rdata[31];
    assign unused_ok = ^{committed_is_branch, commit_pc, commit_result};
`endif

    always_comb begin
        pipe_d             = pipe_q;
        pipe_d.pc          = bus.imem_addr;
        pipe_d.instruction = bus.imem_rdata;
        pipe_d.branch      = br_dec;
        pipe_d.jump        = jmp_dec;
        pipe_d.prediction  = pred;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= BOOT;
            pipe_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            if (adv) begin
                pipe_q  <= pipe_d;
                valid_q <= 1'b1;
            end
            unique case (state_q)
                BOOT:    state_q <= RUN;
                RUN:     state_q <= RUN;
                default: state_q <= BOOT;
            endcase
        end
    end

    assign bus.pipe_out   = pipe_q;
    assign bus.pipe_valid = valid_q;
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: handshake, pre-decode, prediction, reset.
// BHT training checks are compiled in when FETCH_BHT_EN is defined.
module tb_fetch_unit;
    import fetch_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc_update;
    logic        mispredicted;
    logic        committed_is_branch;
    logic [31:0] commit_pc;
    logic        commit_result;
    logic        iq_full;
    logic        ovr_en;
    logic [31:0] ovr;

    int n_cmp = 0;
    int n_bad = 0;

    fetch_unit_if ifc();

    // Default memory content is a non-branch ADDI tagged with its address.
    assign ifc.imem_rdata = ovr_en ? ovr : {ifc.imem_addr[24:0], 7'h13};
    assign ifc.iq_full    = iq_full;

    fetch_unit dut (
        .clk                 (clk),
        .reset               (reset),
        .pc_update           (pc_update),
        .mispredicted        (mispredicted),
        .committed_is_branch (committed_is_branch),
        .commit_pc           (commit_pc),
        .commit_result       (commit_result),
        .bus                 (ifc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic train(input logic [31:0] pc, input logic res, input int n);
        committed_is_branch = 1'b1;
        commit_pc           = pc;
        commit_result       = res;
        repeat (n) step();
        committed_is_branch = 1'b0;
    endtask

    initial begin
        reset               = 1'b1;
        pc_update           = 32'h4;
        mispredicted        = 1'b0;
        committed_is_branch = 1'b0;
        commit_pc           = 32'h0;
        commit_result       = 1'b0;
        iq_full             = 1'b0;
        ovr_en              = 1'b0;
        ovr                 = 32'h0;

        step();
        step();
        chk("rst_valid", ifc.pipe_valid, 1'b0);
        chk("rst_pipe", ifc.pipe_out, '0);
        chk("rst_addr", ifc.imem_addr, 32'h0);

        reset = 1'b0;
        #1;
        chk("boot_addr", ifc.imem_addr, 32'h0);
        step();
        chk("first_valid", ifc.pipe_valid, 1'b1);
        chk("first_pc", ifc.pipe_out.pc, 32'h0);
        chk("first_insn", ifc.pipe_out.instruction, 32'h13);
        chk("run_addr", ifc.imem_addr, 32'h4);
        step();
        chk("second_pc", ifc.pipe_out.pc, 32'h4);
        chk("second_insn", ifc.pipe_out.instruction, 32'h213);

        iq_full   = 1'b1;
        pc_update = 32'h20;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_pc", ifc.pipe_out.pc, 32'h4);
            chk("stall_valid", ifc.pipe_valid, 1'b1);
        end
        iq_full = 1'b0;
        step();
        chk("unstall_pc", ifc.pipe_out.pc, 32'h20);
        chk("unstall_insn", ifc.pipe_out.instruction, 32'h1013);

        iq_full      = 1'b1;
        mispredicted = 1'b1;
        pc_update    = 32'h100;
        step();
        chk("mispred_pc", ifc.pipe_out.pc, 32'h100);
        mispredicted = 1'b0;
        pc_update    = 32'h104;
        step();
        chk("full_hold_pc", ifc.pipe_out.pc, 32'h100);
        iq_full = 1'b0;

        ovr_en    = 1'b1;
        ovr       = 32'h0000_006F;
        pc_update = 32'h200;
        step();
        chk("jal_pc", ifc.pipe_out.pc, 32'h200);
        chk("jal_jump", ifc.pipe_out.jump, 1'b1);
        chk("jal_branch", ifc.pipe_out.branch, 1'b0);
        chk("jal_pred", ifc.pipe_out.prediction, 1'b0);

        ovr       = 32'hFE00_0EE3;
        pc_update = 32'h300;
        step();
        chk("bwd_branch", ifc.pipe_out.branch, 1'b1);
        chk("bwd_jump", ifc.pipe_out.jump, 1'b0);
`ifdef FETCH_BHT_EN
        chk("bwd_pred", ifc.pipe_out.prediction, 1'b0);
`else
        chk("bwd_pred", ifc.pipe_out.prediction, 1'b1);
`endif

        ovr = 32'h0000_0063;
        step();
        chk("fwd_branch", ifc.pipe_out.branch, 1'b1);
        chk("fwd_pred", ifc.pipe_out.prediction, 1'b0);

        ovr_en    = 1'b0;
        pc_update = 32'h3C0;
        reset     = 1'b1;
        #1;
        chk("midrst_addr", ifc.imem_addr, 32'h0);
        step();
        chk("midrst_valid", ifc.pipe_valid, 1'b0);
        chk("midrst_pc", ifc.pipe_out.pc, 32'h0);
        reset = 1'b0;
        step();
        chk("reboot_pc", ifc.pipe_out.pc, 32'h0);
        chk("reboot_valid", ifc.pipe_valid, 1'b1);

`ifdef FETCH_BHT_EN
        pc_update = 32'h10;
        train(32'h40, 1'b1, 2);
        ovr_en    = 1'b1;
        ovr       = 32'h0000_0063;
        pc_update = 32'h40;
        step();
        chk("bht_2taken", ifc.pipe_out.prediction, 1'b1);

        pc_update = 32'h10;
        train(32'h40, 1'b1, 5);
        train(32'h40, 1'b0, 2);
        pc_update = 32'h40;
        step();
        chk("bht_sat_dn", ifc.pipe_out.prediction, 1'b0);

        pc_update = 32'h10;
        train(32'h140, 1'b1, 1);
        pc_update = 32'h40;
        step();
        chk("bht_alias", ifc.pipe_out.prediction, 1'b1);

        pc_update = 32'h10;
        train(32'h40, 1'b0, 1);
        pc_update = 32'h40;
        train(32'h40, 1'b1, 1);
        chk("bht_same_old", ifc.pipe_out.prediction, 1'b0);
        step();
        chk("bht_same_new", ifc.pipe_out.prediction, 1'b1);
        ovr_en = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
